// File: rtl/vsa_imem_loader.sv
// Instruction memory for the VSA core: cleared to FILL after reset, then loaded
// one word at a time over a valid/ready port, then exposed read-only to the core.
module vsa_imem_loader #(
    parameter int          DEPTH = 16,
    parameter logic [11:0] FILL  = 12'h600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [11:0] ld_data,
    input  logic        ld_last,
    input  logic [4:0]  PC,
    output logic [11:0] instruction,
    output logic        run,
    output logic [4:0]  load_count,
    output logic        err
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [4:0]     COUNT_MAX = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [4:0]    load_count_q, load_count_d;
    logic          ld_ready_q, ld_ready_d;
    logic          run_q, run_d;
    logic          err_q, err_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [11:0]   mem_wdata;
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] rd_addr;
    logic          transfer;

    // ld_ready_q is only ever high in LOAD, so it doubles as the accept qualifier.
    assign transfer = ld_valid && ld_ready_q;

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wptr_d       = wptr_q;
        load_count_d = load_count_q;
        ld_ready_d   = ld_ready_q;
        run_d        = run_q;
        err_d        = err_q;
        mem_we       = 1'b0;
        mem_waddr    = clr_ptr_q;
        mem_wdata    = FILL;

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = FILL;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d    = S_LOAD;
                    ld_ready_d = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end

            S_LOAD: begin
                if (transfer) begin
                    mem_we       = 1'b1;
                    mem_waddr    = wptr_q;
                    mem_wdata    = ld_data;
                    load_count_d = (load_count_q == COUNT_MAX) ? load_count_q
                                                               : load_count_q + 5'd1;
                    // The pointer parks at the top word instead of wrapping onto word 0.
                    if (wptr_q != LAST_ADDR) begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (ld_last) begin
                        state_d    = S_RUN;
                        ld_ready_d = 1'b0;
                        run_d      = 1'b1;
                    end else if (wptr_q == LAST_ADDR) begin
                        state_d    = S_ERR;
                        ld_ready_d = 1'b0;
                        err_d      = 1'b1;
                    end
                end
            end

            S_RUN: begin
                ld_ready_d = 1'b0;
                run_d      = 1'b1;
                err_d      = 1'b0;
            end

            S_ERR: begin
                ld_ready_d = 1'b0;
                run_d      = 1'b0;
                err_d      = 1'b1;
            end

            default: begin
                state_d    = S_CLEAR;
                clr_ptr_d  = '0;
                ld_ready_d = 1'b0;
                run_d      = 1'b0;
                err_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            clr_ptr_q    <= '0;
            wptr_q       <= '0;
            load_count_q <= '0;
            ld_ready_q   <= 1'b0;
            run_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wptr_q       <= wptr_d;
            load_count_q <= load_count_d;
            ld_ready_q   <= ld_ready_d;
            run_q        <= run_d;
            err_q        <= err_d;
        end
    end

    // Contents survive reset on purpose; only the CLEAR pass afterwards restores FILL.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // The core fetches at even PCs only; halving drops the odd bit.
    assign rd_addr     = AW'(PC >> 1);
    assign instruction = run_q ? mem[rd_addr] : FILL;

    assign ld_ready   = ld_ready_q;
    assign run        = run_q;
    assign err        = err_q;
    assign load_count = load_count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(run_q && err_q));
            assert (load_count_q <= COUNT_MAX);
        end
    end

endmodule

// File: tb/tb_vsa_imem_loader.sv
// Scenario bench for vsa_imem_loader: a word model tracks loads, reads are queued
// with their expected word and checked on the following falling edge.
module tb_vsa_imem_loader;

    localparam logic [11:0] FILL = 12'h600;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [11:0] ld_data = 12'h000;
    logic        ld_last = 1'b0;
    logic [4:0]  PC = 5'd0;
    logic [11:0] instruction;
    logic        run;
    logic [4:0]  load_count;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_mem [16];
    int          exp_wptr;
    int          exp_count;
    bit          exp_run;
    logic [11:0] sb_q [$];
    logic [11:0] sb_exp;

    vsa_imem_loader #(.DEPTH(16), .FILL(12'h600)) dut (
        .clock       (clock),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .PC          (PC),
        .instruction (instruction),
        .run         (run),
        .load_count  (load_count),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Pending reads are resolved half a cycle after PC is driven.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            sb_exp = sb_q.pop_front();
            n_cmp++;
            if (instruction !== sb_exp) begin
                n_err++;
                $display("FAIL read PC=%0d: got %h want %h", PC, instruction, sb_exp);
            end else begin
                $display("read PC=%0d -> %h", PC, instruction);
            end
        end
    end

    always @(negedge clock) begin
        if (run === 1'b1 && err === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_err_exclusive: got run=%b err=%b want not both 1", run, err);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_mem[i] = FILL;
        exp_wptr  = 0;
        exp_count = 0;
        exp_run   = 1'b0;
    endtask

    // Leaves time at 1ns after the last posedge that sampled reset high.
    task automatic do_reset(input int cycles);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ld_ready); end
        n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL rst_run: got %b want 0", run); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (load_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", load_count); end
        reset = 1'b0;
        model_reset();
        $display("reset %0d cycle(s)", cycles);
    endtask

    task automatic wait_ready();
        int cyc;
        bit bad;
        cyc = 0;
        bad = 1'b0;
        while (ld_ready !== 1'b1 && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            if (run !== 1'b0 || instruction !== FILL) bad = 1'b1;
        end
        n_cmp++;
        if (cyc != 16) begin
            n_err++;
            $display("FAIL clear_latency: got %0d cycles want 16", cyc);
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL clear_outputs: got run/instruction disturbed want run=0 instr=%h", FILL);
        end
        $display("clear done after %0d cycles", cyc);
    endtask

    task automatic send_word(input logic [11:0] d, input bit last);
        int t;
        t        = 0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        while (ld_ready !== 1'b1 && t < 40) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got ld_ready=%b want 1", ld_ready);
        end else begin
            @(posedge clock);
            #1;
            exp_mem[exp_wptr] = d;
            if (exp_wptr < 15) exp_wptr++;
            if (exp_count < 16) exp_count++;
            if (last) exp_run = 1'b1;
            $display("load %h last=%0d", d, last);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic issue_read(input logic [4:0] pc);
        PC = pc;
        sb_q.push_back(exp_run ? exp_mem[pc >> 1] : FILL);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset(3);
        wait_ready();
        do_reset(1);
        wait_ready();
        n_cmp++; if (load_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", load_count); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        issue_read(5'd0);
        issue_read(5'd31);
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        wait_ready();
        send_word(12'h0A1, 1'b0);
        send_word(12'h2C4, 1'b0);
        send_word(12'h6D8, 1'b1);
        n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL b2b_run: got %b want 1", run); end
        n_cmp++; if (load_count !== 5'd3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", load_count); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b want 0", ld_ready); end
        issue_read(5'd0);
        issue_read(5'd3);
        issue_read(5'd4);
        issue_read(5'd30);
        n_cmp++; if (instruction !== 12'h600) begin n_err++; $display("FAIL b2b_pc30: got %h want 600", instruction); end
        ld_valid = 1'b1;
        ld_data  = 12'hFFF;
        ld_last  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_cmp++; if (load_count !== 5'd3) begin n_err++; $display("FAIL run_ignore_count: got %0d want 3", load_count); end
        issue_read(5'd1);
    endtask

    task automatic test_toggle();
        logic [11:0] words [5];
        words[0] = 12'h0A1; words[1] = 12'h2C4; words[2] = 12'h6D8;
        words[3] = 12'h135; words[4] = 12'h7FE;
        do_reset(1);
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            send_word(words[i], i == 4);
            if (i < 4) begin
                @(posedge clock);
                #1;
                n_cmp++;
                if (load_count !== 5'(i + 1)) begin
                    n_err++;
                    $display("FAIL toggle_idle_count: got %0d want %0d", load_count, i + 1);
                end
            end
        end
        n_cmp++; if (load_count !== 5'd5) begin n_err++; $display("FAIL toggle_count: got %0d want 5", load_count); end
        n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL toggle_run: got %b want 1", run); end
        for (int pc = 0; pc < 32; pc++) issue_read(5'(pc));
    endtask

    task automatic test_overflow();
        do_reset(1);
        wait_ready();
        for (int i = 0; i < 16; i++) send_word(12'h100 + 12'(i), 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ovf_err: got %b want 1", err); end
        n_cmp++; if (run !== 1'b0) begin n_err++; $display("FAIL ovf_run: got %b want 0", run); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %b want 0", ld_ready); end
        n_cmp++; if (load_count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", load_count); end
        ld_valid = 1'b1;
        ld_data  = 12'hABC;
        ld_last  = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_cmp++; if (load_count !== 5'd16) begin n_err++; $display("FAIL ovf_hold_count: got %0d want 16", load_count); end
        n_cmp++; if (err !== 1'b1 || run !== 1'b0) begin n_err++; $display("FAIL ovf_hold_state: got err=%b run=%b want err=1 run=0", err, run); end
        issue_read(5'd30);
    endtask

    task automatic test_full_last();
        do_reset(1);
        wait_ready();
        for (int i = 0; i < 16; i++) send_word(12'h800 + 12'(i * 3), i == 15);
        n_cmp++; if (run !== 1'b1) begin n_err++; $display("FAIL full_run: got %b want 1", run); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", err); end
        n_cmp++; if (load_count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d want 16", load_count); end
        issue_read(5'd31);
        issue_read(5'd0);
        issue_read(5'd17);
    endtask

    task automatic test_reset_in_run();
        do_reset(1);
        wait_ready();
        for (int i = 0; i < 4; i++) send_word(12'hA00 + 12'(i), i == 3);
        issue_read(5'd2);
        do_reset(1);
        wait_ready();
        send_word(12'h055, 1'b1);
        n_cmp++; if (load_count !== 5'd1) begin n_err++; $display("FAIL rerun_count: got %0d want 1", load_count); end
        issue_read(5'd2);
        issue_read(5'd0);
    endtask

    task automatic test_reset_priority();
        do_reset(1);
        wait_ready();
        send_word(12'h111, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 12'h123;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        ld_valid = 1'b0;
        model_reset();
        n_cmp++; if (load_count !== 5'd0) begin n_err++; $display("FAIL prio_count: got %0d want 0", load_count); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL prio_ready: got %b want 0", ld_ready); end
        wait_ready();
        send_word(12'h321, 1'b1);
        issue_read(5'd0);
        issue_read(5'd2);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_overflow();
        test_full_last();
        test_reset_in_run();
        test_reset_priority();
        repeat (2) @(posedge clock);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
